// File: rtl/ext_cpu_obi_pkg.sv
// OBI request/response structures shared by the external CPU system interconnect.
package ext_cpu_obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/ext_cpu_obi_arbiter.sv
// Round-robin OBI arbiter: N masters share one slave port, responses are routed back
// in order through a small FIFO of granted master indices.
module ext_cpu_obi_arbiter
  import ext_cpu_obi_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  master_req_i  [NUM_MASTERS],
  output obi_resp_t master_resp_o [NUM_MASTERS],
  output obi_req_t  slave_req_o,
  input  obi_resp_t slave_resp_i,
  output logic      err_o
);

  localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  logic [IdxW-1:0] rr_ptr_q, locked_idx_q;
  logic            lock_q, err_q;
  logic [IdxW-1:0] id_q [MAX_OUTSTANDING];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic [IdxW-1:0] sel, cand, head;
  logic            found, can_issue, fwd_req, hs, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // A response arriving this cycle frees a slot for a new grant in the same cycle.
  assign can_issue = (count_q < CntW'(MAX_OUTSTANDING)) ||
                     (slave_resp_i.rvalid && (count_q == CntW'(MAX_OUTSTANDING)));
  assign pop  = slave_resp_i.rvalid && (count_q != '0);
  assign head = id_q[rd_ptr_q];
  assign hs   = fwd_req && slave_resp_i.gnt;

  always_comb begin
    sel   = rr_ptr_q;
    cand  = '0;
    found = 1'b0;
    if (lock_q) begin
      sel = locked_idx_q;
    end else begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        cand = IdxW'((32'(rr_ptr_q) + i) % NUM_MASTERS);
        if (!found && master_req_i[cand].req) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end
  end

  always_comb begin
    fwd_req         = master_req_i[sel].req && can_issue;
    slave_req_o     = master_req_i[sel];
    slave_req_o.req = fwd_req;
  end

  always_comb begin
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      master_resp_o[m] = '0;
    end
    master_resp_o[sel].gnt = hs;
    if (pop) begin
      master_resp_o[head].rvalid = 1'b1;
      master_resp_o[head].rdata  = slave_resp_i.rdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      locked_idx_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      if (hs) begin
        id_q[wr_ptr_q] <= sel;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
        rr_ptr_q       <= (sel == IdxW'(NUM_MASTERS - 1)) ? '0 : sel + 1'b1;
        lock_q         <= 1'b0;
      end else if (fwd_req) begin
        // Hold the selection until granted so the slave sees a stable address phase.
        lock_q       <= 1'b1;
        locked_idx_q <= sel;
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CntW'(hs) - CntW'(pop);
      if (slave_resp_i.rvalid && (count_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_ext_cpu_obi_arbiter.sv
// Randomized scoreboard bench for ext_cpu_obi_arbiter against a queue-based reference model.
module tb_ext_cpu_obi_arbiter;
  import ext_cpu_obi_pkg::*;

  localparam int N   = 2;
  localparam int MAX = 2;

  logic      clk = 1'b0;
  logic      rst_i;
  obi_req_t  mreq  [N];
  obi_resp_t mresp [N];
  obi_req_t  sreq;
  obi_resp_t sresp;
  logic      err_o;

  ext_cpu_obi_arbiter #(
    .NUM_MASTERS    (N),
    .MAX_OUTSTANDING(MAX)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .master_req_i (mreq),
    .master_resp_o(mresp),
    .slave_req_o  (sreq),
    .slave_resp_i (sresp),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          skip;
    bit          req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    bit          err;
    int          ngnt;
    int          nrv;
  } cyc_t;

  typedef struct {
    int          m;
    logic [31:0] d;
  } rsp_t;

  cyc_t cyc_q[$];
  int   gnt_q[$];
  rsp_t rsp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: outstanding transactions are just a queue of master ids.
  int m_rr, m_lidx;
  bit m_lock, m_err;
  int m_out[$];

  // Stimulus-side master state: a request is held until the model says it was granted.
  bit          pend  [N];
  logic [31:0] paddr [N];
  logic [31:0] pwdata[N];
  logic        pwe   [N];
  logic [3:0]  pbe   [N];

  task automatic drive_masters();
    for (int m = 0; m < N; m++) begin
      mreq[m].req   = pend[m];
      mreq[m].addr  = paddr[m];
      mreq[m].wdata = pwdata[m];
      mreq[m].we    = pwe[m];
      mreq[m].be    = pbe[m];
    end
  endtask

  task automatic cycle(input bit rst, input int preq, input int pgnt, input int prv,
                       input int pspur);
    cyc_t c;
    int   n, sel;
    bit   can, sr, hs, pop;
    @(posedge clk);
    #1;
    c = '{default: 0};
    if (rst) begin
      rst_i        = 1'b1;
      drive_masters();
      sresp.gnt    = 1'($urandom_range(0, 1));
      sresp.rvalid = 1'b1;
      sresp.rdata  = $urandom;
      m_out.delete();
      m_rr   = 0;
      m_lock = 0;
      m_lidx = 0;
      m_err  = 0;
      c.skip = 1;
      cyc_q.push_back(c);
      return;
    end
    rst_i = 1'b0;
    for (int m = 0; m < N; m++) begin
      if (!pend[m] && $urandom_range(0, 99) < preq) begin
        pend[m]   = 1;
        paddr[m]  = {(m == 0) ? 8'hA0 : 8'hB0, 24'($urandom)};
        pwdata[m] = $urandom;
        pwe[m]    = 1'($urandom_range(0, 1));
        pbe[m]    = 4'($urandom);
      end
    end
    drive_masters();
    n            = m_out.size();
    sresp.gnt    = ($urandom_range(0, 99) < pgnt);
    sresp.rvalid = (n > 0) ? ($urandom_range(0, 99) < prv) : ($urandom_range(0, 99) < pspur);
    sresp.rdata  = $urandom;

    can = (n < MAX) || (sresp.rvalid && n == MAX);
    sel = m_rr;
    if (m_lock) begin
      sel = m_lidx;
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pend[(m_rr + i) % N]) sel = (m_rr + i) % N;
      end
    end
    sr  = pend[sel] && can;
    hs  = sr && sresp.gnt;
    pop = sresp.rvalid && n > 0;

    c.req   = sr;
    c.addr  = paddr[sel];
    c.wdata = pwdata[sel];
    c.we    = pwe[sel];
    c.be    = pbe[sel];
    c.err   = m_err;
    c.ngnt  = hs ? 1 : 0;
    c.nrv   = pop ? 1 : 0;
    cyc_q.push_back(c);
    if (hs) gnt_q.push_back(sel);
    if (pop) rsp_q.push_back('{m: m_out[0], d: sresp.rdata});

    if (pop) void'(m_out.pop_front());
    if (sresp.rvalid && n == 0) m_err = 1;
    if (hs) begin
      m_out.push_back(sel);
      m_rr      = (sel + 1) % N;
      m_lock    = 0;
      pend[sel] = 0;
    end else if (sr) begin
      m_lock = 1;
      m_lidx = sel;
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin
    cyc_t c;
    int   ng, nr, eg;
    rsp_t er;
    forever begin
      @(negedge clk);
      if (cyc_q.size() == 0) continue;
      c = cyc_q.pop_front();
      if (c.skip) continue;
      chk("slave_req", 32'(sreq.req), 32'(c.req));
      if (c.req && sreq.req) begin
        chk("slave_addr", sreq.addr, c.addr);
        chk("slave_wdata", sreq.wdata, c.wdata);
        chk("slave_we", 32'(sreq.we), 32'(c.we));
        chk("slave_be", 32'(sreq.be), 32'(c.be));
      end
      chk("err", 32'(err_o), 32'(c.err));
      ng = 0;
      nr = 0;
      for (int m = 0; m < N; m++) begin
        if (mresp[m].gnt) begin
          ng++;
          eg = (gnt_q.size() > 0) ? gnt_q.pop_front() : -1;
          chk("gnt_master", m, eg);
        end
        if (mresp[m].rvalid) begin
          nr++;
          if (rsp_q.size() > 0) er = rsp_q.pop_front();
          else er = '{m: -1, d: 32'hDEAD_BEEF};
          chk("rvalid_master", m, er.m);
          chk("rdata", mresp[m].rdata, er.d);
        end else begin
          chk("rdata_idle", mresp[m].rdata, 32'h0);
        end
      end
      chk("gnt_count", ng, c.ngnt);
      chk("rvalid_count", nr, c.nrv);
    end
  end

  initial begin
    rst_i = 1'b1;
    sresp = '0;
    for (int m = 0; m < N; m++) begin
      pend[m]   = 0;
      paddr[m]  = '0;
      pwdata[m] = '0;
      pwe[m]    = 1'b0;
      pbe[m]    = '0;
      mreq[m]   = '0;
    end
    m_rr   = 0;
    m_lock = 0;
    m_lidx = 0;
    m_err  = 0;

    repeat (2) cycle(1, 0, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);                 // idle reset-state outputs
    repeat (40) cycle(0, 100, 100, 100, 0);          // saturated round-robin
    repeat (300) cycle(0, 50, 70, 40, 3);            // mixed traffic, waits and stalls
    repeat (40) cycle(0, 80, 90, 5, 0);              // outstanding limit pressure
    repeat (4) cycle(0, 100, 20, 0, 0);              // build up lock and outstanding
    cycle(1, 0, 0, 0, 0);                            // reset mid-transaction
    cycle(0, 0, 0, 0, 100);                          // late/spurious response sets err
    repeat (200) cycle(0, 60, 60, 50, 2);
    repeat (30) cycle(0, 0, 100, 100, 0);            // drain
    @(negedge clk);
    @(negedge clk);
    chk("leftover_cycles", cyc_q.size(), 0);
    chk("leftover_gnts", gnt_q.size(), 0);
    chk("leftover_rsps", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
